// File: rtl/seq_pattern_tx_if.sv
// Bus between a frame requester and the seq_pattern_tx serial transmitter.
// start is a request that is taken only while busy=0; out_valid=1 marks out as a sync/payload bit.
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8,
  parameter int GAP_W  = 4,
  parameter int CNT_W  = 4
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic [GAP_W-1:0]  gap_len;
  logic [CNT_W-1:0]  nframes;
  logic              out;
  logic              out_valid;
  logic              busy;
  logic              frame_done;
  logic              done;

  modport master (
    input  start, data, gap_len, nframes,
    output out, out_valid, busy, frame_done, done
  );

  modport slave (
    output start, data, gap_len, nframes,
    input  out, out_valid, busy, frame_done, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern, payload (incrementing per frame), optional idle gap.
// All bus outputs are registered from the next-state decode, so they line up with r_state.
module seq_pattern_tx #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               DATA_W  = 8,
  parameter int               GAP_W   = 4,
  parameter int               CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_pattern_tx_if.master     bus,
  output logic [1:0]           o_state
);

  localparam int MAXB = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int CW0  = $clog2(MAXB);
  localparam int CW   = (CW0 > GAP_W) ? CW0 : GAP_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_frame, w_frame_nxt;
  logic [CNT_W-1:0]  r_nframes, w_nframes_nxt;
  logic [DATA_W-1:0] r_payload, w_payload_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;

  logic r_out, r_valid, r_busy, r_fdone, r_done;
  logic w_out_nxt, w_valid_nxt, w_busy_nxt, w_fdone_nxt, w_done_nxt;

  logic w_sync_last, w_data_last, w_gap_last, w_last_frame;
  logic [PAT_W-1:0]  w_pat_sh;
  logic [DATA_W-1:0] w_pay_sh;

  assign w_sync_last  = (r_cnt == CW'(PAT_W - 1));
  assign w_data_last  = (r_cnt == CW'(DATA_W - 1));
  assign w_gap_last   = ((r_cnt + CW'(1)) == CW'(r_gap));
  assign w_last_frame = (r_frame == r_nframes);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_frame   <= '0;
      r_nframes <= '0;
      r_payload <= '0;
      r_gap     <= '0;
      r_out     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_fdone   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_frame   <= w_frame_nxt;
      r_nframes <= w_nframes_nxt;
      r_payload <= w_payload_nxt;
      r_gap     <= w_gap_nxt;
      r_out     <= w_out_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_fdone   <= w_fdone_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_frame_nxt   = r_frame;
    w_nframes_nxt = r_nframes;
    w_payload_nxt = r_payload;
    w_gap_nxt     = r_gap;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = S_SYNC;
          w_cnt_nxt     = '0;
          w_frame_nxt   = '0;
          w_nframes_nxt = bus.nframes;
          w_payload_nxt = bus.data;
          w_gap_nxt     = bus.gap_len;
        end
      end
      S_SYNC: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_sync_last) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_data_last) begin
          w_cnt_nxt = '0;
          if (w_last_frame) begin
            w_state_nxt = S_IDLE;
          end else begin
            // Next frame carries the following payload value; wraps naturally.
            w_frame_nxt   = r_frame + 1'b1;
            w_payload_nxt = r_payload + 1'b1;
            w_state_nxt   = (r_gap != '0) ? S_GAP : S_SYNC;
          end
        end
      end
      S_GAP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_gap_last) begin
          w_state_nxt = S_SYNC;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy matches r_state.
  always_comb begin
    w_pat_sh    = PATTERN << w_cnt_nxt;
    w_pay_sh    = w_payload_nxt << w_cnt_nxt;
    w_out_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_SYNC: begin
        w_out_nxt   = w_pat_sh[PAT_W-1];
        w_valid_nxt = 1'b1;
      end
      S_DATA: begin
        w_out_nxt   = w_pay_sh[DATA_W-1];
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_fdone_nxt = (r_state == S_DATA) && w_data_last;
    w_done_nxt  = w_fdone_nxt && w_last_frame;
  end

  assign bus.out        = r_out;
  assign bus.out_valid  = r_valid;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_fdone;
  assign bus.done       = r_done;
  assign o_state        = r_state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle expected stream plus hand-computed totals.
module tb_seq_pattern_tx;
  localparam int W = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  seq_pattern_tx_if #(.DATA_W(8), .GAP_W(4), .CNT_W(4)) bus();

  seq_pattern_tx dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference non-overlapping Moore 1101 detector fed by the serial line
  typedef enum logic [2:0] {D0, D1, D11, D110, D1101} det_t;
  det_t det_st;
  int   det_q[$];
  always @(posedge clk) begin
    if (reset) det_st <= D0;
    else begin
      case (det_st)
        D0:      det_st <= bus.out ? D1   : D0;
        D1:      det_st <= bus.out ? D11  : D0;
        D11:     det_st <= bus.out ? D11  : D110;
        D110:    det_st <= bus.out ? D1101 : D0;
        default: det_st <= bus.out ? D1   : D0;
      endcase
    end
  end
  always @(negedge clk) if (det_st == D1101) det_q.push_back(cyc);

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_total = 0;
  int           n_pass  = 0;
  int           busy_cnt, done_cnt, fd_cnt, t0;
  logic [31:0]  bits;
  logic [3:0]   pat = 4'b1101;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {out, out_valid, busy, frame_done, done} for every cycle after start.
  task automatic build_exp(input logic [7:0] d, input logic [3:0] g, input logic [3:0] nf);
    logic [7:0] p;
    logic       fd;
    int         nfi;
    int         gi;
    fd  = 1'b0;
    nfi = int'(nf);
    gi  = int'(g);
    for (int k = 0; k <= nfi; k++) begin
      p = d + 8'(k);
      for (int i = 3; i >= 0; i--) begin
        exp_q.push_back({pat[i], 1'b1, 1'b1, fd, 1'b0});
        fd = 1'b0;
      end
      for (int j = 7; j >= 0; j--) exp_q.push_back({p[j], 1'b1, 1'b1, 1'b0, 1'b0});
      fd = 1'b1;
      if (k < nfi) begin
        for (int q = 0; q < gi; q++) begin
          exp_q.push_back({1'b0, 1'b0, 1'b1, fd, 1'b0});
          fd = 1'b0;
        end
      end
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic drain(input string tag);
    logic [W-1:0] obs;
    bits     = '0;
    busy_cnt = 0;
    done_cnt = 0;
    fd_cnt   = 0;
    while (exp_q.size() > 0) begin
      obs = {bus.out, bus.out_valid, bus.busy, bus.frame_done, bus.done};
      chk(tag, 32'(obs), 32'(exp_q.pop_front()));
      if (bus.busy)       busy_cnt++;
      if (bus.done)       done_cnt++;
      if (bus.frame_done) fd_cnt++;
      if (bus.out_valid)  bits = {bits[30:0], bus.out};
      if (exp_q.size() > 0) tick();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] g, input logic [3:0] nf,
                      input string tag);
    bus.data    = d;
    bus.gap_len = g;
    bus.nframes = nf;
    bus.start   = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    build_exp(d, g, nf);
    drain(tag);
  endtask

  initial begin
    logic       seen;
    logic [W-1:0] obs;
    bus.start   = 1'b0;
    bus.data    = '0;
    bus.gap_len = '0;
    bus.nframes = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("reset_state", {25'd0, bus.out, bus.out_valid, bus.busy, bus.frame_done, bus.done,
                        dbg_state}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", {27'd0, bus.out, bus.out_valid, bus.busy, bus.frame_done,
                             bus.done}, 32'd0);

    // single frame A5
    send(8'hA5, 4'd0, 4'd0, "single");
    chk("single_bits", bits, 32'h0000_0DA5);
    chk("single_busy", 32'(busy_cnt), 32'd12);
    chk("single_done", 32'(done_cnt), 32'd1);

    // two frames, gap 2, payload wraps FF -> 00
    tick();
    send(8'hFF, 4'd2, 4'd1, "multi");
    chk("multi_bits", bits, 32'h00DF_FD00);
    chk("multi_busy", 32'(busy_cnt), 32'd26);
    chk("multi_fdone", 32'(fd_cnt), 32'd2);
    chk("multi_done", 32'(done_cnt), 32'd1);

    // start held high: ignored while busy, re-accepted in the done cycle
    tick();
    bus.data    = 8'hA5;
    bus.gap_len = 4'd0;
    bus.nframes = 4'd0;
    bus.start   = 1'b1;
    tick();
    build_exp(8'hA5, 4'd0, 4'd0);
    drain("hold_first");
    chk("hold_first_done", 32'(done_cnt), 32'd1);
    tick();
    build_exp(8'hA5, 4'd0, 4'd0);
    obs = {bus.out, bus.out_valid, bus.busy, bus.frame_done, bus.done};
    chk("hold_restart", 32'(obs), 32'(exp_q.pop_front()));
    bus.start = 1'b0;
    tick();
    drain("hold_second");

    // reset in the middle of DATA
    tick();
    bus.data  = 8'hA5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("midreset_outputs", {25'd0, bus.out, bus.out_valid, bus.busy, bus.frame_done,
                             bus.done, dbg_state}, 32'd0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | bus.frame_done | bus.done | bus.busy;
    end
    chk("midreset_quiet", 32'(seen), 32'd0);
    send(8'h3C, 4'd0, 4'd0, "after_reset");
    chk("after_reset_bits", bits, 32'h0000_0D3C);

    // loopback into the 1101 detector
    tick();
    tick();
    det_q.delete();
    send(8'h00, 4'd3, 4'd3, "loopback");
    chk("loop_busy", 32'(busy_cnt), 32'd57);
    chk("loop_det_count", 32'(det_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < det_q.size()) chk("loop_det_time", 32'(det_q[k] - t0), 32'(5 + 15 * k));
    end

    // sixteen contiguous frames 10..1F
    tick();
    send(8'h10, 4'd0, 4'd15, "sixteen");
    chk("sixteen_bits", bits, 32'h1DD1_ED1F);
    chk("sixteen_busy", 32'(busy_cnt), 32'd192);
    chk("sixteen_fdone", 32'(fd_cnt), 32'd16);
    chk("sixteen_done", 32'(done_cnt), 32'd1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial frame transmitter, the transmit end of the team's Moore "1101" sequence detectors. On a start request it emits one or more frames, MSB-first, one bit per clock. Each frame is a fixed sync pattern (default 1101), then a payload word, then an optional idle gap. Its serial output drives detector `in` pins directly, both in the datapath and in loopback benches.

Parameters:
- PAT_W, 4, sync pattern width in bits
- PATTERN, 4'b1101, sync pattern; bit PAT_W-1 is sent first
- DATA_W, 8, payload width in bits
- GAP_W, 4, width of the inter-frame gap length field
- CNT_W, 4, width of the frame-count field

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to send; sampled only when busy=0
- data  input  DATA_W  payload for the first frame; latched on accepted start
- gap_len  input  GAP_W  idle bits between frames; latched on accepted start
- nframes  input  CNT_W  frames to send minus 1; latched on accepted start
- out  output  1  serial bit stream
- out_valid  output  1  high while out carries a sync or payload bit
- busy  output  1  high from the cycle after an accepted start through the last payload bit
- frame_done  output  1  one-cycle pulse in the cycle after each frame's last payload bit
- done  output  1  one-cycle pulse in the cycle after the final frame's last payload bit

Behaviour:
- One clock domain. Reset is synchronous and active-high; the clock and reset ports are named clk and reset.
- All outputs are registered (Moore style).
- Reset values: out=0, out_valid=0, busy=0, frame_done=0, done=0, state=IDLE, all counters 0.
- Reset mid-operation aborts the transfer. The next cycle shows the reset values, and no done or frame_done pulse is emitted.
- States and transitions:
  - IDLE -> SYNC on start=1.
  - SYNC -> DATA after PAT_W bits.
  - DATA -> GAP after DATA_W bits, when frames remain and gap_len>0.
  - DATA -> SYNC after DATA_W bits, when frames remain and gap_len=0.
  - DATA -> IDLE after DATA_W bits of the last frame.
  - GAP -> SYNC after gap_len cycles.
- Start acceptance: start=1 is accepted in any IDLE cycle, including the cycle in which done=1. On acceptance, data, gap_len and nframes are latched. Start is ignored while busy=1.
- Latency: the first sync bit (PATTERN[PAT_W-1]) appears on out, with out_valid=1 and busy=1, in the cycle after start is accepted.
- SYNC: out = PATTERN[PAT_W-1-i] for i = 0..PAT_W-1.
- DATA: out = payload[DATA_W-1-j] for j = 0..DATA_W-1.
- Payload arithmetic: frame k (k = 0..nframes) sends (data + k) mod 2^DATA_W. The increment wraps, e.g. 8'hFF -> 8'h00.
- GAP and IDLE: out=0 and out_valid=0. The line idles low so a downstream detector sees no false pattern.
- GAP timing: GAP lasts exactly gap_len cycles; busy stays 1 during GAP.
- Frame count: exactly nframes+1 frames are sent. nframes=0 sends one frame; nframes=2^CNT_W-1 sends 2^CNT_W frames.
- frame_done: pulses 1 in the cycle after the last payload bit of every frame. This cycle is the first GAP, SYNC or IDLE cycle.
- done: pulses 1 together with the last frame_done. busy=0 in that same cycle.
- Back-to-back transfers: a start in the done cycle gives a new first sync bit in the next cycle, with no extra idle cycle.
- Total busy cycles: (nframes+1)*(PAT_W+DATA_W) + nframes*gap_len.

Test Plan:
- Single frame: reset 2 cycles, then data=8'hA5, gap_len=0, nframes=0, start for 1 cycle at T0 -> out over T1..T12 = 1,1,0,1,1,0,1,0,0,1,0,1 with out_valid=1. At T13: busy=0, done=1, frame_done=1, out=0.
- Multi-frame with gap and wrap: data=8'hFF, gap_len=2, nframes=1.
  - Frame 0 payload is FF; frame_done pulses at T13.
  - T13..T14: out_valid=0, out=0, busy=1.
  - Frame 1 (sync at T15..T18) has payload 8'h00.
  - done at T27; total busy cycles = 26.
- Start ignored while busy: hold start=1 through the whole transfer with nframes=0 -> exactly one frame is sent. A second frame starts at T14, because the start held high in the done cycle T13 is accepted.
- Reset mid-DATA: assert reset at T7 -> at T8 out=0, out_valid=0, busy=0, with no done or frame_done pulse. A new start is then accepted normally.
- Loopback to the 1101 non-overlapping Moore detector: data=8'h00, gap_len=3, nframes=3 -> the detector output asserts exactly 4 times, each 1 cycle after a frame's last sync bit.
- nframes=15, gap_len=0, data=8'h10 -> 16 contiguous frames with payloads 8'h10..8'h1F. busy stays high for 192 cycles; done pulses once.
